// File: rtl/knob_quadrature_emitter_pkg.sv
// Shared types for the quadrature emitter: FSM states, direction codes
// and the per-direction phase -> (A,B) line table.
package knob_quadrature_emitter_pkg;

  localparam int unsigned POS_W = 12;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
  } quad_lines_t;

  // Every detent leaves from and returns to (0,0); CW leads with B, CCW with A.
  function automatic quad_lines_t phase_lines(input state_t st, input logic dir);
    quad_lines_t l;
    l.a = 1'b0;
    l.b = 1'b0;
    case (st)
      PH1: begin
        l.a = (dir == DIR_CW) ? 1'b0 : 1'b1;
        l.b = (dir == DIR_CW) ? 1'b1 : 1'b0;
      end
      PH2: begin
        l.a = 1'b1;
        l.b = 1'b1;
      end
      PH3: begin
        l.a = (dir == DIR_CW) ? 1'b1 : 1'b0;
        l.b = (dir == DIR_CW) ? 1'b0 : 1'b1;
      end
      default: begin
        l.a = 1'b0;
        l.b = 1'b0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/knob_quadrature_emitter_quad_phase_timer.sv
// Phase timer: counts 0..PHASE_TICKS-1, flags the last tick, restarts on clear.
module knob_quadrature_emitter_quad_phase_timer #(
  parameter int unsigned PHASE_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_last_c
);

  localparam int unsigned TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;

  logic [TW-1:0] count;

  assign tick_last_c = (count == TW'(PHASE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick_last_c) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/knob_quadrature_emitter.sv
// Rotary encoder emulator: turns step commands into rotA/rotB quadrature detents,
// tracking remaining detents and a wrapping signed position.
module knob_quadrature_emitter
  import knob_quadrature_emitter_pkg::*;
#(
  parameter int unsigned PHASE_TICKS = 1000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    qzt_clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic                    abort,
  output logic                    rotA,
  output logic                    rotB,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        steps_left,
  output logic signed [POS_W-1:0] position
);

  state_t                    state, state_next;
  logic                      dir_q, dir_next;
  logic [CNT_W-1:0]          steps_next;
  logic signed [POS_W-1:0]   pos_next;
  logic                      abort_pending, abort_next;
  logic                      done_next, busy_next, ready_next;
  quad_lines_t               lines_next;
  logic                      accept_c, tick_last_c, timer_clear_c;

  assign accept_c = cmd_valid && cmd_ready;

  // Timer restarts on every state change so each phase lasts exactly PHASE_TICKS.
  assign timer_clear_c = (state_next != state) || (state == IDLE);

  knob_quadrature_emitter_quad_phase_timer #(
    .PHASE_TICKS(PHASE_TICKS)
  ) u_timer (
    .clk        (qzt_clk),
    .rst_n      (rst_n),
    .clear      (timer_clear_c),
    .tick_last_c(tick_last_c)
  );

  always_comb begin
    state_next = state;
    dir_next   = dir_q;
    steps_next = steps_left;
    pos_next   = position;
    done_next  = 1'b0;
    abort_next = abort_pending;

    case (state)
      IDLE: begin
        if (accept_c) begin
          dir_next   = cmd_dir;
          steps_next = cmd_count;
          if (cmd_count != '0) begin
            state_next = PH1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      PH1: if (tick_last_c) state_next = PH2;
      PH2: if (tick_last_c) state_next = PH3;
      PH3: if (tick_last_c) state_next = PH4;
      PH4: begin
        if (tick_last_c) begin
          pos_next   = (dir_q == DIR_CCW) ? position - POS_W'(1) : position + POS_W'(1);
          steps_next = steps_left - CNT_W'(1);
          if ((steps_left == CNT_W'(1)) || abort_pending || abort) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = PH1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort only matters once a command is running; it never cuts a detent short.
    if (state_next == IDLE) begin
      abort_next = 1'b0;
    end else if (abort && (state != IDLE)) begin
      abort_next = 1'b1;
    end

    busy_next  = (state_next != IDLE);
    ready_next = (state_next == IDLE);
    lines_next = phase_lines(state, dir_q);
  end

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir_q         <= DIR_CW;
      steps_left    <= '0;
      position      <= '0;
      abort_pending <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      cmd_ready     <= 1'b1;
      rotA          <= 1'b0;
      rotB          <= 1'b0;
    end else begin
      state         <= state_next;
      dir_q         <= dir_next;
      steps_left    <= steps_next;
      position      <= pos_next;
      abort_pending <= abort_next;
      done          <= done_next;
      busy          <= busy_next;
      cmd_ready     <= ready_next;
      rotA          <= lines_next.a;
      rotB          <= lines_next.b;
    end
  end

endmodule

// File: tb/tb_knob_quadrature_emitter.sv
// Directed bench for knob_quadrature_emitter: command table, abort, reset and
// position-wrap sequences, plus a simple detent decoder on the lines.
module tb_knob_quadrature_emitter;

  localparam int unsigned PT    = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          DET   = 4 * PT;

  logic               qzt_clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [CNT_W-1:0]   cmd_count;
  logic               abort;
  logic               rotA;
  logic               rotB;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   steps_left;
  logic signed [11:0] position;

  always #5 qzt_clk = ~qzt_clk;

  knob_quadrature_emitter #(
    .PHASE_TICKS(PT),
    .CNT_W      (CNT_W)
  ) dut (
    .qzt_clk   (qzt_clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .abort     (abort),
    .rotA      (rotA),
    .rotB      (rotB),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left),
    .position  (position)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [11:0] model_pos;
  int ctrl_out = 0;

  logic [1:0] cw_seq  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] ccw_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  typedef struct {
    logic dir;
    int   count;
    int   abort_k;
    bit   busy_cmd;
    int   done_k;
    int   end_pos;
    int   end_steps;
  } vec_t;

  vec_t vecs [5];

  // Detent decoder: a detent counts only when the lines return to 00
  // after a complete CW or CCW sequence.
  logic [1:0] ctl_prev = 2'b00;
  logic [1:0] ctl_first = 2'b00;
  always @(negedge qzt_clk) begin
    logic [1:0] cur;
    cur = {rotA, rotB};
    if (ctl_prev == 2'b00 && cur != 2'b00) ctl_first <= cur;
    if (ctl_prev != 2'b00 && cur == 2'b00) begin
      if (ctl_first == 2'b01 && ctl_prev == 2'b10) ctrl_out <= ctrl_out + 1;
      else if (ctl_first == 2'b10 && ctl_prev == 2'b01) ctrl_out <= ctrl_out - 1;
    end
    ctl_prev <= cur;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // abort_k: -1 none, -2 asserted together with the accept, else cycle k after accept.
  task automatic run_cmd(input logic dir, input int count, input int abort_k,
                         input bit busy_cmd, input int done_k,
                         input int end_pos, input int end_steps);
    int emitted;
    int p0;
    int sgn;
    int d;
    int ph;
    logic [1:0] exp_lines;
    logic signed [11:0] ep;
    emitted = done_k / DET;
    p0 = int'(model_pos);
    sgn = dir ? 1 : -1;
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = CNT_W'(count);
    abort     = (abort_k == -2);
    @(negedge qzt_clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    for (int k = 0; k <= done_k + 2; k++) begin
      d = (k / DET < emitted) ? k / DET : emitted;
      exp_lines = 2'b00;
      if (k >= 1 && (k - 1) < emitted * DET) begin
        ph = ((k - 1) / PT) % 4;
        exp_lines = dir ? cw_seq[ph] : ccw_seq[ph];
      end
      ep = 12'(p0 + sgn * d);
      check("lines", int'({rotA, rotB}), int'(exp_lines));
      check("done", int'(done), (k == done_k) ? 1 : 0);
      check("busy", int'(busy), (count > 0 && k < done_k) ? 1 : 0);
      check("cmd_ready", int'(cmd_ready), (count > 0 && k < done_k) ? 0 : 1);
      check("steps_left", int'(steps_left), count - d);
      check("position", int'(position), int'(ep));
      abort = (k == abort_k);
      if (busy_cmd) begin
        cmd_valid = (k >= 2 && k < done_k - 1);
        cmd_dir   = ~dir;
        cmd_count = CNT_W'(7);
      end
      @(negedge qzt_clk);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    model_pos = 12'(p0 + sgn * emitted);
    check("end_position", int'(position), end_pos);
    check("end_steps_left", int'(steps_left), end_steps);
  endtask

  initial begin
    int ctrl0;
    vecs[0] = '{1'b1, 3, -1, 1'b1, 48, 3, 0};
    vecs[1] = '{1'b0, 2, -1, 1'b0, 32, 1, 0};
    vecs[2] = '{1'b1, 5, 22, 1'b0, 32, 3, 3};
    vecs[3] = '{1'b1, 0, -1, 1'b0, 0, 3, 0};
    vecs[4] = '{1'b0, 1, -1, 1'b1, 16, 2, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b1; cmd_count = '0; abort = 1'b0;
    model_pos = '0;
    repeat (3) @(posedge qzt_clk);
    @(negedge qzt_clk);
    check("rst_lines", int'({rotA, rotB}), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_position", int'(position), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_steps_left", int'(steps_left), 0);
    rst_n = 1'b1;
    @(negedge qzt_clk);

    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].dir, vecs[i].count, vecs[i].abort_k, vecs[i].busy_cmd,
              vecs[i].done_k, vecs[i].end_pos, vecs[i].end_steps);
    end

    // Abort in IDLE is ignored; abort coinciding with accept is ignored too.
    abort = 1'b1;
    @(negedge qzt_clk);
    abort = 1'b0;
    @(negedge qzt_clk);
    ctrl0 = ctrl_out;
    run_cmd(1'b1, 4, -2, 1'b0, 64, 6, 0);
    run_cmd(1'b0, 1, -1, 1'b0, 16, 5, 0);
    repeat (2) @(negedge qzt_clk);
    check("ctrl_delta", ctrl_out - ctrl0, 3);

    // Reset in the middle of PH2: lines drop, partial detent not counted.
    ctrl0 = ctrl_out;
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = CNT_W'(2);
    @(negedge qzt_clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge qzt_clk);
    check("mid_ph2_lines", int'({rotA, rotB}), 3);
    rst_n = 1'b0;
    @(negedge qzt_clk);
    rst_n = 1'b1;
    check("rst_mid_lines", int'({rotA, rotB}), 0);
    check("rst_mid_position", int'(position), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    check("rst_mid_steps", int'(steps_left), 0);
    repeat (2) @(negedge qzt_clk);
    check("rst_mid_ctrl", ctrl_out, ctrl0);
    check("rst_mid_lines_idle", int'({rotA, rotB}), 0);
    model_pos = '0;

    // Walk position up to 2047, then across both wrap boundaries.
    for (int i = 0; i < 8; i++) begin
      run_cmd(1'b1, 255, -1, 1'b0, 255 * DET, (i + 1) * 255, 0);
    end
    run_cmd(1'b1, 7, -1, 1'b0, 7 * DET, 2047, 0);
    run_cmd(1'b1, 1, -1, 1'b0, DET, -2048, 0);
    run_cmd(1'b0, 1, -1, 1'b0, DET, 2047, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
